btn_bounce_gen: RTL
===================

# btn_bounce_gen

Button-press emulator: converts a single-cycle press request into a physically realistic, bouncing active-high button waveform, followed by a clean hold, a bouncing release, and a settle period. It is the driving end of the board's button-input path. Its `btn_out` feeds the button debouncer, either through a loopback pin or directly in simulation, for self-test and regression. Bounce timing comes from a deterministic LFSR, so every run is reproducible.

## Interface
- `CLK_HZ`, 125_000_000, clock frequency in Hz.
- `BOUNCE_MS`, 2, length of each bounce window (press and release), in ms.
- `HOLD_MS`, 20, stable pressed time, and stable released settle time, in ms. Must exceed the downstream debounce time.
- `SEG_BITS`, 10, width of the bounce segment length field. Segment length range is 1..2^SEG_BITS cycles.
- `LFSR_SEED`, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'h0001.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `press_req`  in  1  single-cycle request to emulate one press/release.
- `btn_out`  out  1  emulated button level (1 = pressed), registered.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse at sequence completion.

## Operation
- Derived constants:
  - BOUNCE_CYC = (CLK_HZ/1000)*BOUNCE_MS.
  - HOLD_CYC = (CLK_HZ/1000)*HOLD_MS.
  - Counter widths = $clog2 of the larger constant, plus 1.
- States: IDLE → P_BNC → P_HOLD → R_BNC → R_SETTLE → IDLE.
- IDLE:
  - `press_req`=1 moves to P_BNC.
  - On that edge: `btn_out`<=1, `busy`<=1, window counter cleared, segment counter loaded.
- Segment counter:
  - Loaded with L = 1 + lfsr[SEG_BITS-1:0]; the LFSR advances on every load.
  - Decrements each cycle.
  - When it would expire after L cycles at the current level, `btn_out` toggles and the counter reloads.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. It never reaches 0.
- P_BNC:
  - Lasts exactly BOUNCE_CYC cycles, counted from the first cycle `btn_out`=1.
  - On exit, `btn_out`<=1 regardless of toggle phase.
- P_HOLD:
  - Lasts HOLD_CYC cycles with `btn_out` constant 1. No toggles; the LFSR does not advance.
- R_BNC:
  - Entry edge: `btn_out`<=0 and the segment counter is loaded.
  - Toggling follows the same rules as P_BNC, for BOUNCE_CYC cycles.
  - On exit, `btn_out`<=0.
- R_SETTLE:
  - Lasts HOLD_CYC cycles with `btn_out`=0.
  - On exit: `busy`<=0, `done`<=1 for one cycle, state IDLE.
- `press_req` outside IDLE is ignored. There is no queuing.
- A `press_req` in the same cycle that `done`=1 (state already IDLE) starts a new sequence.
- The LFSR is not reseeded between sequences. Consecutive sequences use a continuing random stream.

## Timing
- Reset (async, immediate): `btn_out`=0, `busy`=0, `done`=0, state IDLE, LFSR=seed, all counters 0.
- Reset mid-sequence: outputs drop to the reset values in the same cycle. No `done` is produced.
- Latency: `press_req` sampled at edge t; `btn_out`=1 and `busy`=1 from cycle t+1.
- `busy` duration: exactly 2*BOUNCE_CYC + 2*HOLD_CYC cycles.
- `done`: asserted on the first cycle with `busy`=0.
- Level timing: each bounce level lasts 1..2^SEG_BITS cycles. The final level of a window may be truncated by the window end.
- Guaranteed stable intervals:
  - `btn_out`=1 for cycles t+1+BOUNCE_CYC through t+BOUNCE_CYC+HOLD_CYC.
  - `btn_out`=0 from t+1+2*BOUNCE_CYC+HOLD_CYC onward.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BOUNCE_MS=1, HOLD_MS=20, SEG_BITS=4. This gives BOUNCE_CYC=1000 and HOLD_CYC=20000.

1. Reset: assert `rst` with `press_req`=0 → `btn_out`=0, `busy`=0, `done`=0. Assert `rst` asynchronously mid-clock → outputs go to 0 before the next edge.
2. Single press, `press_req` at edge t → all of:
   - `btn_out`=1 at t+1.
   - `busy` high for exactly 42000 cycles.
   - `btn_out` constant 1 over t+1001..t+21000.
   - `btn_out` constant 0 from t+22001.
   - `done`=1 for exactly one cycle at t+42001.
3. Segment bounds: every `btn_out` level inside either bounce window lasts 1..16 cycles, except the truncated last one. At least 62 toggles per window.
4. Handshake:
   - `press_req` pulses at t+5 and t+30000 → ignored; still exactly one `done`.
   - `press_req` in the `done` cycle → new sequence, with `btn_out`=1 on the next cycle.
5. Determinism: reset mid-P_HOLD, then `press_req` → `btn_out`=0 and `busy`=0 at reset. The toggle timestamps of the new P_BNC match those of the first run cycle-for-cycle.
6. Loopback: `btn_out` into the board debouncer (same CLK_HZ, DEBOUNCE_MS=10); 3 back-to-back sequences → exactly 3 debounced pulses, one per press.

Source files
------------

// File: rtl/btn_bounce_gen.sv
// Button-press emulator: turns a single-cycle request into a bouncing press,
// a clean hold, a bouncing release and a settle period, using LFSR timing.
module btn_bounce_gen #(
  parameter int unsigned CLK_HZ    = 125_000_000,
  parameter int unsigned BOUNCE_MS = 2,
  parameter int unsigned HOLD_MS   = 20,
  parameter int unsigned SEG_BITS  = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic press_req,
  output logic btn_out,
  output logic busy,
  output logic done
);

  localparam int unsigned BOUNCE_CYC = (CLK_HZ / 1000) * BOUNCE_MS;
  localparam int unsigned HOLD_CYC   = (CLK_HZ / 1000) * HOLD_MS;
  localparam int unsigned MAX_CYC    = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC) + 1;
  localparam int unsigned SEG_W      = SEG_BITS + 1;
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] TAPS       = 16'hB400;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_P_BNC    = 3'd1;
  localparam logic [2:0] S_P_HOLD   = 3'd2;
  localparam logic [2:0] S_R_BNC    = 3'd3;
  localparam logic [2:0] S_R_SETTLE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             btn_q, btn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [15:0]      lfsr_step;
  logic [SEG_W-1:0] seg_load;
  logic             bnc_end;
  logic             hold_end;

  // Next LFSR value and the segment length drawn from the current one.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    seg_load  = SEG_W'(lfsr_q[SEG_BITS-1:0]) + SEG_W'(1);
    bnc_end   = (win_q == CNT_W'(BOUNCE_CYC - 1));
    hold_end  = (win_q == CNT_W'(HOLD_CYC - 1));
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    seg_d   = seg_q;
    lfsr_d  = lfsr_q;
    btn_d   = btn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press_req) begin
          state_d = S_P_BNC;
          btn_d   = 1'b1;
          busy_d  = 1'b1;
          win_d   = '0;
          seg_d   = seg_load;
          lfsr_d  = lfsr_step;
        end
      end

      // Both bounce windows share toggle rules; the window end forces the final level.
      S_P_BNC, S_R_BNC: begin
        if (bnc_end) begin
          win_d   = '0;
          btn_d   = (state_q == S_P_BNC);
          state_d = (state_q == S_P_BNC) ? S_P_HOLD : S_R_SETTLE;
        end else begin
          win_d = win_q + CNT_W'(1);
          if (seg_q == SEG_W'(1)) begin
            btn_d  = ~btn_q;
            seg_d  = seg_load;
            lfsr_d = lfsr_step;
          end else begin
            seg_d = seg_q - SEG_W'(1);
          end
        end
      end

      S_P_HOLD: begin
        if (hold_end) begin
          win_d   = '0;
          state_d = S_R_BNC;
          btn_d   = 1'b0;
          seg_d   = seg_load;
          lfsr_d  = lfsr_step;
        end else begin
          win_d = win_q + CNT_W'(1);
        end
      end

      S_R_SETTLE: begin
        if (hold_end) begin
          win_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          win_d = win_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        btn_d   = 1'b0;
        busy_d  = 1'b0;
        win_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      seg_q   <= '0;
      lfsr_q  <= SEED;
      btn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      seg_q   <= seg_d;
      lfsr_q  <= lfsr_d;
      btn_q   <= btn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign btn_out = btn_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
